wb_sig_reader: RTL and testbench



---
 rtl/wb_sig_reader_if.sv | 33 +++
 rtl/wb_sig_reader.sv | 209 ++++++++++++++++++++
 tb/tb_wb_sig_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sig_reader_if.sv
// Purpose: bundles the Wishbone B4 pipelined read port and the signature word stream of wb_sig_reader.
// Latency: none, wires only.
// Backpressure: wb_stall_i throttles requests; sig_ready_i throttles the stream.
// Ports: master = the reader (drives cyc/stb/adr, sinks ack/data, sources stream);
//        slave  = memory plus stream consumer (the opposite directions).
interface wb_sig_reader_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;
    logic        sig_valid_o;
    logic        sig_ready_i;
    logic [31:0] sig_data_o;
    logic        sig_last_o;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        input  wb_stall_i, wb_ack_i, wb_dat_i,
        output sig_valid_o, sig_data_o, sig_last_o,
        input  sig_ready_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        output wb_stall_i, wb_ack_i, wb_dat_i,
        input  sig_valid_o, sig_data_o, sig_last_o,
        output sig_ready_i
    );
endinterface

// File: rtl/wb_sig_reader.sv
// Purpose: Wishbone B4 pipelined initiator that reads words [begin, end) and streams them in address order.
// Latency: first request one cycle after start; a word acked at edge n is stream-valid after edge n.
// Backpressure: requests are credit-limited so outstanding + buffered never exceeds DEPTH; stream holds while !ready.
// Ports: clk, rst_n (async active-low); start_i/begin_addr_i/end_addr_i command; busy_o/done_o/err_o status;
//        bus = wb_sig_reader_if.master (Wishbone read port + sig_* stream).
// Optional: define WB_SIG_READER_TIMEOUT_EN to build the ack watchdog (TIMEOUT_CYCLES) and the err_o flag.

// Purpose: generic synchronous FIFO, power-of-two depth.
// Latency: a word written at edge n is readable after edge n.
// Backpressure: writes while full are dropped; the caller guarantees space.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign wr_en  = wr_vld && (count != FULL_C);
    assign rd_en  = rd_rdy && rd_vld;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module wb_sig_reader #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] begin_addr_i,
    input  logic [31:0] end_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    wb_sig_reader_if.master bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [31:0]     next_adr, ack_adr, end_w;
    logic [31:0]     begin_in_w, end_in_w;
    logic [CW-1:0]   outstanding, outst_nxt;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     inflight;
    logic            credit, req_acc, ack_ok, last_req, abort;
    logic            start_acc, fifo_vld, fifo_pop, flush_empty;
    logic [32:0]     fifo_head;
    logic            unused_lsbs;

    assign begin_in_w  = {begin_addr_i[31:2], 2'b00};
    assign end_in_w    = {end_addr_i[31:2], 2'b00};
    assign unused_lsbs = &{1'b0, begin_addr_i[1:0], end_addr_i[1:0]};

    assign start_acc = (state == IDLE) && start_i;

    // Outstanding requests plus buffered words may never exceed the FIFO depth,
    // so every ack is guaranteed a slot.
    assign inflight = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign credit   = inflight < DEPTH_C;
    assign req_acc  = bus.wb_stb_o && !bus.wb_stall_i;
    assign ack_ok   = bus.wb_ack_i && (outstanding != '0);
    assign last_req = (next_adr == end_w - 32'd4);

    assign fifo_pop    = fifo_vld && bus.sig_ready_i;
    // FIFO will be empty after this edge (no pushes happen in FLUSH).
    assign flush_empty = (fifo_cnt == '0) || ((fifo_cnt == ONE_C) && fifo_pop);

    assign bus.wb_we_o  = 1'b0;
    assign bus.wb_sel_o = 4'hF;
    assign bus.wb_adr_o = next_adr;
    assign busy_o       = (state != IDLE);

    always_comb begin
        outst_nxt = outstanding;
        if (req_acc && !ack_ok)      outst_nxt = outstanding + ONE_C;
        else if (!req_acc && ack_ok) outst_nxt = outstanding - ONE_C;
        if (abort)                   outst_nxt = '0;
    end

    always_comb begin
        state_nxt    = state;
        bus.wb_cyc_o = 1'b0;
        bus.wb_stb_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) state_nxt = (end_in_w > begin_in_w) ? ISSUE : FLUSH;
            end
            ISSUE: begin
                bus.wb_cyc_o = 1'b1;
                bus.wb_stb_o = credit;
                if (abort)                    state_nxt = FLUSH;
                else if (req_acc && last_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.wb_cyc_o = 1'b1;
                if (abort || (outst_nxt == '0)) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_empty) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            next_adr    <= '0;
            ack_adr     <= '0;
            end_w       <= '0;
            outstanding <= '0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= outst_nxt;
            done_o      <= (state == FLUSH) && flush_empty;
            if (start_acc) begin
                next_adr <= begin_in_w;
                ack_adr  <= begin_in_w;
                end_w    <= end_in_w;
            end else begin
                if (req_acc) next_adr <= next_adr + 32'd4;
                if (ack_ok)  ack_adr  <= ack_adr + 32'd4;
            end
        end
    end

    // Acks return in request order, so ack_adr tracks the address of each returning word.
    fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (ack_ok),
        .wr_dat ({ack_adr == end_w - 32'd4, bus.wb_dat_i}),
        .rd_rdy (bus.sig_ready_i),
        .rd_vld (fifo_vld),
        .rd_dat (fifo_head),
        .count  (fifo_cnt)
    );

    assign bus.sig_valid_o = fifo_vld;
    assign bus.sig_data_o  = fifo_vld ? fifo_head[31:0] : 32'h0;
    assign bus.sig_last_o  = fifo_vld && fifo_head[32];

`ifdef WB_SIG_READER_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // Fires on the cycle that would be the TIMEOUT_CYCLES-th consecutive ack-less wait.
    assign abort = (outstanding != '0) && !bus.wb_ack_i && (to_cnt == TO_LAST);
    assign err_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (bus.wb_ack_i || (outstanding == '0) || abort) to_cnt <= '0;
            else                                                to_cnt <= to_cnt + TW'(1);
            if (start_acc)  err_q <= 1'b0;
            else if (abort) err_q <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_sig_reader.sv
// Purpose: self-checking bench for wb_sig_reader: table-driven ranges plus hand sequences for
//          start timing, ignored restart, empty range, mid-operation reset and the ack watchdog.
// Latency/backpressure: slave acks one cycle after acceptance; stall and ready patterns per vector.
module tb_wb_sig_reader;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] begin_addr = '0;
    logic [31:0] end_addr = '0;
    logic        busy, done, err;

    wb_sig_reader_if bus();

    wb_sig_reader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .begin_addr_i (begin_addr),
        .end_addr_i   (end_addr),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    typedef struct { logic [31:0] dat; logic last; } exp_t;
    exp_t        sb[$];
    logic [31:0] pending[$];

    int stall_mode = 0, ready_mode = 0, ready_hold = 0;
    bit hang = 0;
    int words_seen, done_cnt, stb_cnt, cyc_cnt, inflight, credit_viol, stable_viol, valid_cnt;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_dat = '0;

    // Pipelined slave: one-cycle ack, optional stall pattern, optional hang; also drives stream ready.
    initial begin
        logic        acc;
        logic [31:0] a;
        bus.wb_stall_i  = 1'b0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_dat_i    = '0;
        bus.sig_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            acc = rst_n && bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_stall_i;
            a   = bus.wb_adr_o;
            @(posedge clk);
            #1;
            if (!rst_n)   pending.delete();
            else if (acc) pending.push_back(a);
            if (rst_n && !hang && pending.size() > 0) begin
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = mem_word(pending.pop_front());
            end else begin
                bus.wb_ack_i = 1'b0;
                bus.wb_dat_i = 32'hDEAD_BEEF;
            end
            case (stall_mode)
                1:       bus.wb_stall_i = ~bus.wb_stall_i;
                2:       bus.wb_stall_i = 1'($urandom_range(0, 1));
                default: bus.wb_stall_i = 1'b0;
            endcase
            if (ready_hold > 0) begin
                ready_hold--;
                bus.sig_ready_i = 1'b0;
            end else if (ready_mode == 1) begin
                bus.sig_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                bus.sig_ready_i = 1'b1;
            end
        end
    end

    // Monitor: stream scoreboard, bus counters, credit and hold-stable rules.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (bus.wb_cyc_o) cyc_cnt++;
                if (bus.wb_stb_o && inflight >= DEPTH) credit_viol++;
                if (prev_hold && (!bus.sig_valid_o || bus.sig_data_o !== prev_dat)) stable_viol++;
                prev_hold = bus.sig_valid_o && !bus.sig_ready_i;
                prev_dat  = bus.sig_data_o;
                if (bus.sig_valid_o) valid_cnt++;
                if (done) done_cnt++;
                if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_stall_i) begin
                    stb_cnt++;
                    inflight++;
                end
                if (bus.sig_valid_o && bus.sig_ready_i) begin
                    words_seen++;
                    inflight--;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got 0x%08h, expected no word", bus.sig_data_o);
                    end else begin
                        e = sb.pop_front();
                        check("stream_data", bus.sig_data_o, e.dat);
                        check("stream_last", 32'(bus.sig_last_o), 32'(e.last));
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        words_seen = 0; done_cnt = 0; stb_cnt = 0; cyc_cnt = 0;
        inflight = 0; credit_viol = 0; stable_viol = 0; valid_cnt = 0;
        pending.delete();
        sb.delete();
    endtask

    task automatic expect_range(input logic [31:0] b, input logic [31:0] e);
        logic [31:0] bw, ew;
        bw = {b[31:2], 2'b00};
        ew = {e[31:2], 2'b00};
        if (ew > bw)
            for (logic [31:0] a = bw; a != ew; a += 32'd4)
                sb.push_back('{mem_word(a), a == ew - 32'd4});
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] e);
        @(posedge clk); #1;
        begin_addr = b;
        end_addr   = e;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] b, e;
        int          stall, ready, hold, exp_words;
    } vec_t;

    task automatic run_vec(input vec_t v);
        clear_stats();
        stall_mode = v.stall;
        ready_mode = v.ready;
        expect_range(v.b, v.e);
        @(posedge clk); #1;
        begin_addr = v.b;
        end_addr   = v.e;
        start_i    = 1'b1;
        ready_hold = v.hold;
        @(posedge clk); #1;
        start_i    = 1'b0;
        @(negedge clk);
        check({v.name, "_busy_after_start"}, 32'(busy), 32'd1);
        check({v.name, "_err_cleared"}, 32'(err), 32'd0);
        wait_done(v.name, 3000);
        repeat (4) @(negedge clk);
        check({v.name, "_words"}, 32'(words_seen), 32'(v.exp_words));
        check({v.name, "_sb_left"}, 32'(sb.size()), 32'd0);
        check({v.name, "_done_count"}, 32'(done_cnt), 32'd1);
        check({v.name, "_stb_handshakes"}, 32'(stb_cnt), 32'(v.exp_words));
        check({v.name, "_credit_viol"}, 32'(credit_viol), 32'd0);
        check({v.name, "_stable_viol"}, 32'(stable_viol), 32'd0);
        check({v.name, "_cyc_idle"}, 32'(bus.wb_cyc_o), 32'd0);
        check({v.name, "_err_end"}, 32'(err), 32'd0);
    endtask

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic",    32'h8000_0000, 32'h8000_0010, 0, 0, 0,  4};
        vecs[1] = '{"empty",    32'h0000_0100, 32'h0000_0100, 0, 0, 0,  0};
        vecs[2] = '{"backpres", 32'h8000_0000, 32'h8000_0010, 1, 0, 20, 4};
        vecs[3] = '{"wrap",     32'hFFFF_FFF8, 32'h0000_0008, 0, 0, 0,  0};
        vecs[4] = '{"reverse",  32'h0000_0040, 32'h0000_0020, 0, 0, 0,  0};
        vecs[5] = '{"random",   32'h1000_0000, 32'h1000_0040, 2, 1, 0, 16};
        vecs[6] = '{"oneword",  32'h2000_0004, 32'h2000_0009, 0, 0, 0,  1};
        vecs[7] = '{"topmem",   32'hFFFF_FFF0, 32'hFFFF_FFFC, 2, 1, 3,  3};

        // Reset state
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_cyc",   32'(bus.wb_cyc_o), 32'd0);
        check("rst_stb",   32'(bus.wb_stb_o), 32'd0);
        check("rst_adr",   bus.wb_adr_o, 32'h0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_valid", 32'(bus.sig_valid_o), 32'd0);
        check("rst_last",  32'(bus.sig_last_o), 32'd0);
        check("rst_data",  bus.sig_data_o, 32'h0);
        check("tie_we",    32'(bus.wb_we_o), 32'd0);
        check("tie_sel",   32'(bus.wb_sel_o), 32'hF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Empty range: done exactly two edges after start is presented, no bus or stream activity
        clear_stats();
        pulse_start(32'h100, 32'h100);
        @(negedge clk);
        check("empty_busy_e1", 32'(busy), 32'd1);
        check("empty_done_e1", 32'(done), 32'd0);
        @(negedge clk);
        check("empty_done_e2", 32'(done), 32'd1);
        check("empty_busy_e2", 32'(busy), 32'd0);
        @(negedge clk);
        check("empty_done_e3", 32'(done), 32'd0);
        check("empty_cyc_cnt", 32'(cyc_cnt), 32'd0);
        check("empty_valid_cnt", 32'(valid_cnt), 32'd0);

        // Misaligned begin and a start pulse while busy
        clear_stats();
        stall_mode = 0;
        ready_mode = 0;
        expect_range(32'h8000_0000, 32'h8000_0010);
        pulse_start(32'h8000_0003, 32'h8000_0010);
        @(negedge clk);
        check("hs_busy", 32'(busy), 32'd1);
        check("hs_cyc",  32'(bus.wb_cyc_o), 32'd1);
        check("hs_stb",  32'(bus.wb_stb_o), 32'd1);
        check("hs_adr",  bus.wb_adr_o, 32'h8000_0000);
        pulse_start(32'h0000_0200, 32'h0000_0240);
        wait_done("busystart", 200);
        repeat (6) @(negedge clk);
        check("busystart_words", 32'(words_seen), 32'd4);
        check("busystart_done_count", 32'(done_cnt), 32'd1);
        check("busystart_stb", 32'(stb_cnt), 32'd4);
        check("busystart_sb_left", 32'(sb.size()), 32'd0);

        // Reset with two reads outstanding
        clear_stats();
        hang = 1;
        ready_hold = 1000;
        pulse_start(32'h8000_0000, 32'h8000_0010);
        for (int t = 0; t < 50 && stb_cnt < 2; t++) begin
            @(posedge clk); #2;
        end
        check("rstmid_two_out", 32'(stb_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rstmid_cyc",   32'(bus.wb_cyc_o), 32'd0);
        check("rstmid_stb",   32'(bus.wb_stb_o), 32'd0);
        check("rstmid_valid", 32'(bus.sig_valid_o), 32'd0);
        check("rstmid_busy",  32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hang = 0;
        ready_hold = 0;
        @(negedge clk);
        check("rstmid_valid_after", 32'(bus.sig_valid_o), 32'd0);
        run_vec('{"postreset", 32'h3000_0000, 32'h3000_0018, 0, 0, 0, 6});

`ifdef WB_SIG_READER_TIMEOUT_EN
        // Slave never acks: watchdog aborts, err set, done pulses, err cleared by next start
        clear_stats();
        hang = 1;
        stall_mode = 0;
        ready_mode = 0;
        pulse_start(32'h8000_0000, 32'h8000_0010);
        wait_done("timeout", 200);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_cyc_low", 32'(bus.wb_cyc_o), 32'd0);
        check("timeout_cyc_cycles", 32'(cyc_cnt), 32'(TO + 1));
        repeat (3) @(negedge clk);
        check("timeout_words", 32'(words_seen), 32'd0);
        check("timeout_err_sticky", 32'(err), 32'd1);
        hang = 0;
        run_vec('{"after_timeout", 32'h8000_0000, 32'h8000_0010, 0, 0, 0, 4});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
